// File: rtl/uart_rx_mmio.sv
// rtl/uart_rx_mmio.sv - memory-mapped 8N1 UART receiver with byte FIFO (EXISTS/VALUE window)
// Optional sticky overrun flag: define UART_RX_OVERRUN_FLAG_EN.
module uart_rx_mmio #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic          sync1_q, sync2_q, rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic          empty, full, do_push, pop;
    logic [7:0]    head;

    logic          req_ready_q, resp_valid_q;
    logic [31:0]   resp_data_q, resp_data_d;
    logic          accept, rd_exists, rd_value;
    logic          ovr_q;

    logic unused_bits;
    assign unused_bits = ^{req_wdata, req_addr[31:4], req_addr[2:0]};

    assign rx_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Mid-bit recheck rejects short low glitches on the idle line.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    push    = rx_s;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head    = mem_q[rptr_q[AW-1:0]];

    assign accept    = req_valid & req_ready_q;
    assign rd_exists = accept & ~req_wen & ~req_addr[3];
    assign rd_value  = accept & ~req_wen & req_addr[3];
    assign pop       = rd_value & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives then.
    assign do_push   = push & (~full | pop);
    assign wptr_d    = do_push ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;

`ifdef UART_RX_OVERRUN_FLAG_EN
    logic drop, ovr_d;
    assign drop  = push & full & ~pop;
    assign ovr_d = rd_exists ? drop : (ovr_q | drop);
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end
`else
    assign ovr_q = 1'b0;
`endif

    always_comb begin
        resp_data_d = 32'd0;
        if (rd_exists) begin
            resp_data_d = {30'd0, ovr_q, ~empty};
        end else if (rd_value && !empty) begin
            resp_data_d = {24'd0, head};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= shreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shreg_q      <= 8'd0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
        end else begin
            sync1_q      <= uart_rx;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            req_ready_q  <= 1'b1;
            resp_valid_q <= accept;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

endmodule
